// File: rtl/wrr_pkg.sv
// Shared types and helpers for the weighted round-robin arbiter.
package wrr_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_t;

  // Widest flattened weight bus the slice helper accepts.
  localparam int WV_MAX = 256;

  function automatic logic [31:0] onehot(input int unsigned idx);
    return 32'(1) << idx;
  endfunction

  function automatic logic [15:0] weight_of(input logic [WV_MAX-1:0] w,
                                            input int unsigned idx,
                                            input int unsigned ww);
    logic [WV_MAX-1:0] mask;
    mask = (WV_MAX'(1) << ww) - WV_MAX'(1);
    return 16'((w >> (idx * ww)) & mask);
  endfunction

endpackage

// File: rtl/wrr_next_pick.sv
// Circular priority picker: first set bit of elig after ptr, with ptr itself checked last.
module wrr_next_pick #(
  parameter int NUM_CH = 4,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] elig,
  input  logic [SEL_W-1:0]  ptr,
  output logic              found,
  output logic [SEL_W-1:0]  idx
);

  localparam logic [SEL_W:0] NCH = (SEL_W+1)'(NUM_CH);

  logic [SEL_W:0] sum;

  // Walk from farthest to nearest so the nearest eligible channel wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    sum   = '0;
    for (int i = NUM_CH; i >= 1; i--) begin
      sum = {1'b0, ptr} + (SEL_W+1)'(i);
      if (sum >= NCH) sum = sum - NCH;
      if (elig[sum[SEL_W-1:0]]) begin
        found = 1'b1;
        idx   = sum[SEL_W-1:0];
      end
    end
  end

endmodule

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter: each eligible channel gets up to weight[i]
// consecutive transfers before service moves on in circular order.
//   state | meaning
//   IDLE  | nothing granted, waiting for an eligible channel
//   SERVE | channel ptr granted, credit transfers remaining
module wrr_arbiter
  import wrr_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int WEIGHT_W = 4,
  parameter int SEL_W    = $clog2(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enb,
  input  logic [NUM_CH-1:0]            req,
  input  logic [NUM_CH*WEIGHT_W-1:0]   weight,
  input  logic                         ready,
  output logic [NUM_CH-1:0]            grant,
  output logic [SEL_W-1:0]             sel,
  output logic                         valid,
  output logic [NUM_CH-1:0]            pop
);

  state_t              state;
  logic [SEL_W-1:0]    ptr;
  logic [WEIGHT_W-1:0] credit;

  logic [NUM_CH-1:0]   elig;
  logic                found;
  logic [SEL_W-1:0]    pick;
  logic [WEIGHT_W-1:0] pick_w;
  logic                cur_req;
  logic                leave;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_elig
    assign elig[i] = req[i] & (weight_of(WV_MAX'(weight), i, WEIGHT_W) != 16'd0);
  end

  wrr_next_pick #(.NUM_CH(NUM_CH), .SEL_W(SEL_W)) u_pick (
    .elig  (elig),
    .ptr   (ptr),
    .found (found),
    .idx   (pick)
  );

  assign pick_w  = WEIGHT_W'(weight_of(WV_MAX'(weight), 32'(pick), WEIGHT_W));
  assign pop     = {NUM_CH{enb & ready}} & grant & req;
  assign cur_req = |(grant & req);
  // Credit exhausted on this transfer, or the granted FIFO ran dry.
  assign leave   = !cur_req || (ready && credit == WEIGHT_W'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      ptr    <= SEL_W'(NUM_CH - 1);
      credit <= '0;
      grant  <= '0;
      sel    <= '0;
      valid  <= 1'b0;
    end else if (enb) begin
      case (state)
        IDLE: begin
          if (found) begin
            state  <= SERVE;
            ptr    <= pick;
            sel    <= pick;
            grant  <= NUM_CH'(onehot(32'(pick)));
            valid  <= 1'b1;
            credit <= pick_w;
          end
        end
        SERVE: begin
          if (leave) begin
            if (found) begin
              ptr    <= pick;
              sel    <= pick;
              grant  <= NUM_CH'(onehot(32'(pick)));
              credit <= pick_w;
            end else begin
              state  <= IDLE;
              grant  <= '0;
              valid  <= 1'b0;
              credit <= '0;
            end
          end else if (ready) begin
            credit <= credit - WEIGHT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wrr_arbiter.sv
// Directed bench for wrr_arbiter with 4 channels and 4-bit weights.
module tb_wrr_arbiter;

  logic        clk;
  logic        rst;
  logic        enb;
  logic [3:0]  req;
  logic [15:0] weight;
  logic        ready;
  logic [3:0]  grant;
  logic [1:0]  sel;
  logic        valid;
  logic [3:0]  pop;

  int total = 0;
  int bad   = 0;

  wrr_arbiter #(.NUM_CH(4), .WEIGHT_W(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .enb    (enb),
    .req    (req),
    .weight (weight),
    .ready  (ready),
    .grant  (grant),
    .sel    (sel),
    .valid  (valid),
    .pop    (pop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reset pulse between clock edges, then start with the given setup.
  task automatic restart(input logic [15:0] w, input logic [3:0] r);
    rst    = 1'b0;
    enb    = 1'b1;
    weight = w;
    req    = r;
    ready  = 1'b1;
    #1;
    rst    = 1'b1;
  endtask

  int seq_w[12] = '{0, 0, 0, 1, 2, 2, 3, 0, 0, 0, 1, 2};
  int seq_z[8]  = '{0, 0, 2, 3, 0, 0, 2, 3};

  initial begin
    rst = 1'b0; enb = 1'b0; req = '0; weight = '0; ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_grant", grant, 4'b0000);
    chk("reset_sel",   sel,   2'd0);
    chk("reset_valid", valid, 1'b0);
    chk("reset_pop",   pop,   4'b0000);

    // weights ch3..ch0 = 1,2,1,3
    restart({4'd1, 4'd2, 4'd1, 4'd3}, 4'b1111);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk($sformatf("wfair_pop%0d", k), pop, 32'(1) << seq_w[k]);
      chk($sformatf("wfair_valid%0d", k), valid, 1'b1);
    end
    chk("wfair_sel_ch2", sel, 2'd2);

    // async reset mid-service
    #2 rst = 1'b0;
    #1;
    chk("async_grant", grant, 4'b0000);
    chk("async_sel",   sel,   2'd0);
    chk("async_valid", valid, 1'b0);
    chk("async_pop",   pop,   4'b0000);
    enb = 1'b0; weight = {4'd1, 4'd1, 4'd1, 4'd1}; req = 4'b1111; ready = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("enb_low_valid", valid, 1'b0);
    enb = 1'b1;
    @(negedge clk);
    chk("first_grant", grant, 4'b0001);
    chk("first_sel",   sel,   2'd0);

    // zero weight on ch1: weights ch3..ch0 = 1,1,0,2
    restart({4'd1, 4'd1, 4'd0, 4'd2}, 4'b1111);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("zero_pop%0d", k), pop, 32'(1) << seq_z[k]);
    end

    // single requester ch2, weight 2
    restart({4'd1, 4'd2, 4'd1, 4'd1}, 4'b0100);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("single_pop%0d", k),   pop,   4'b0100);
      chk($sformatf("single_grant%0d", k), grant, 4'b0100);
      chk($sformatf("single_valid%0d", k), valid, 1'b1);
    end

    // backpressure during ch0 service, weight 3
    restart({4'd1, 4'd1, 4'd1, 4'd3}, 4'b1111);
    @(negedge clk);
    chk("bp_first_pop", pop, 4'b0001);
    @(posedge clk);
    #1 ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("bp_hold_grant%0d", k), grant, 4'b0001);
      chk($sformatf("bp_hold_pop%0d", k),   pop,   4'b0000);
    end
    ready = 1'b1;
    #1;
    chk("bp_pop2", pop, 4'b0001);
    @(negedge clk);
    chk("bp_pop3", pop, 4'b0001);
    @(negedge clk);
    chk("bp_next_ch1", pop, 4'b0010);

    // early drop of req[0] after one pop, then enable freeze
    restart({4'd1, 4'd1, 4'd1, 4'd3}, 4'b1111);
    @(negedge clk);
    chk("drop_first_pop", pop, 4'b0001);
    @(posedge clk);
    #1 req = 4'b1110;
    @(negedge clk);
    chk("drop_bubble_pop",   pop,   4'b0000);
    chk("drop_bubble_grant", grant, 4'b0001);
    @(negedge clk);
    chk("drop_grant_ch1", grant, 4'b0010);
    chk("drop_pop_ch1",   pop,   4'b0010);
    enb = 1'b0;
    #1;
    chk("freeze_pop_now", pop, 4'b0000);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk($sformatf("freeze_grant%0d", k), grant, 4'b0010);
      chk($sformatf("freeze_sel%0d", k),   sel,   2'd1);
      chk($sformatf("freeze_pop%0d", k),   pop,   4'b0000);
    end
    enb = 1'b1;
    #1;
    chk("thaw_pop", pop, 4'b0010);
    @(negedge clk);
    chk("thaw_next_grant", grant, 4'b0100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wrr_arbiter.md
# wrr_arbiter

Parametrised weighted round-robin arbiter for NUM_CH virtual channels. Each channel with pending data gets up to its weight in consecutive transfers before the arbiter moves to the next requesting channel in circular order. Zero-weight channels are skipped. A downstream ready signal applies backpressure. It sits between the virtual-channel FIFOs and the shared output link, and generalises the fixed 4-channel round-robin to any channel count with per-channel programmable weights.

## Interface
- NUM_CH, 4: number of virtual channels (≥2).
- WEIGHT_W, 4: width of each channel weight; weights 0..2^WEIGHT_W-1.
- SEL_W, $clog2(NUM_CH): width of sel.
- clk  input  1  clock; all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- enb  input  1  enable; low freezes all state and forces pop to 0.
- req  input  NUM_CH  per-channel "has data" level (FIFO not empty).
- weight  input  NUM_CH*WEIGHT_W  channel i weight at bits [i*WEIGHT_W +: WEIGHT_W].
- ready  input  1  downstream accepts a word this cycle.
- grant  output  NUM_CH  registered one-hot grant; all zero when idle.
- sel  output  SEL_W  registered index of the granted channel; holds its last value when idle.
- valid  output  1  registered; high while a channel is granted.
- pop  output  NUM_CH  combinational; pop[i] = enb & grant[i] & req[i] & ready. This is the FIFO read strobe.

## Operation
- Eligible channel: req[i]=1 and weight[i]≠0.
- Internal state: state ∈ {IDLE, SERVE}, ptr (SEL_W), credit (WEIGHT_W).
- Pick function: first eligible channel searching ptr+1, ptr+2, …, ptr, modulo NUM_CH. ptr itself is checked last.
- IDLE: if enb and any channel is eligible, then next cycle state=SERVE, ptr=pick, sel=pick, grant=onehot(pick), valid=1, and credit=weight[pick]. The weight is sampled at this instant.
- SERVE, transfer cycle (pop[ptr]=1): credit decrements.
  - If credit was 1: switch to pick if any channel is eligible, with credit reloaded from the new channel's weight; otherwise go to IDLE with grant=0 and valid=0.
- SERVE, req[ptr]=0: no credit is consumed; switch exactly as for credit exhaustion.
- SERVE, ready=0 with req[ptr]=1: hold everything.
- Weight changes while a channel is being served do not affect its current credit. They take effect at the next selection.
- enb=0: state, ptr, credit, grant, sel and valid all hold; pop=0.
- Reset (any time, including mid-service): state=IDLE, ptr=NUM_CH-1 (so channel 0 is searched first), credit=0, grant=0, sel=0, valid=0. pop=0 immediately.

## Timing
- Grant latency: 1 cycle from the first eligible req in IDLE (with enb=1) to valid=1.
- Channel switch on credit exhaustion has no bubble: the last transfer of channel A is in cycle t, and channel B is granted and can transfer in cycle t+1.
- A req drop on the granted channel costs one non-transfer cycle: the low req is observed in cycle t and the new grant appears in cycle t+1.
- A single eligible channel is re-granted to itself with its credit reloaded. Its transfers are continuous.
- Maximum consecutive transfers for channel i is weight[i].

## Structure
- Package wrr_pkg holds:
  - the state enum (IDLE, SERVE);
  - the onehot helper function;
  - the weight-slice helper function.
- Sub-module wrr_next_pick: combinational circular priority picker.
  - Inputs: eligible vector (NUM_CH) and start index ptr.
  - Outputs: found and idx.
  - It is instantiated once and used for both the IDLE and SERVE decisions.
- Top-level: state/ptr/credit registers, output registers and the pop logic.

## Test plan
- Reset: assert rst low mid-SERVE → grant, sel, valid and pop go to 0 without a clock edge. After release with all req=1 and all weights=1, the first grant is channel 0, one cycle after enb rises.
- Weighted fairness: req=4'b1111, weights (ch0..ch3)=3,1,2,1, ready=1 → the pop channel sequence is 0,0,0,1,2,2,3,0,0,0,… with no idle cycles.
- Zero weight: weights=2,0,1,1 and req=4'b1111 → channel 1 is never granted; the sequence is 0,0,2,3,0,0,…
- Single requester: only req[2]=1, weight 2 → pop[2] is high every cycle; grant stays 4'b0100 and valid stays 1 throughout.
- Backpressure: during a ch0 service with weight 3, hold ready=0 for 3 cycles after the first transfer → grant is held and credit is unchanged. Exactly 2 more ch0 pops follow once ready=1.
- Early drop: ch0 has weight 3; req[0] falls after 1 pop → the next cycle grants ch1 and ch0's remaining credit is discarded. Raising enb=0 mid-service freezes grant and forces pop=0.
